// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multi-cycle multiply/divide unit with forwarded operands and HI/LO
// Results are computed at the start edge, held in pending registers, and committed on completion.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ForwardA,
  input  logic [1:0]  ForwardB,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] FwdE,
  input  logic [31:0] FwdM,
  input  logic [31:0] FwdW,
  input  logic [2:0]  md_op,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CntW = $clog2(MaxCycles + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic [31:0]     pendHi, pendLo;
  logic [31:0]     calcHi, calcLo;
  logic            isMult, isSigned;
  logic [63:0]     prodS, prodU;
  logic [31:0]     magA, magB, divisor, quo, rem;

  always_comb begin
    unique case (ForwardA)
      2'd0: opA = RD1E;
      2'd1: opA = FwdE;
      2'd2: opA = FwdM;
      default: opA = FwdW;
    endcase
    unique case (ForwardB)
      2'd0: opB = RD2E;
      2'd1: opB = FwdE;
      2'd2: opB = FwdM;
      default: opB = FwdW;
    endcase
  end

  assign start    = (md_op >= 3'd1) && (md_op <= 3'd4);
  assign md_stall = start | busy;
  assign isMult   = (md_op == 3'd1) || (md_op == 3'd2);
  assign isSigned = (md_op == 3'd1) || (md_op == 3'd3);

  assign prodS = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};
  assign prodU = {32'd0, opA} * {32'd0, opB};

  // Signed divide works on magnitudes so the INT_MIN / -1 case falls out naturally.
  assign magA    = (isSigned && opA[31]) ? -opA : opA;
  assign magB    = (isSigned && opB[31]) ? -opB : opB;
  assign divisor = (magB == 32'd0) ? 32'd1 : magB;
  assign quo     = magA / divisor;
  assign rem     = magA % divisor;

  always_comb begin
    calcHi = 32'd0;
    calcLo = 32'd0;
    if (isMult) begin
      calcHi = isSigned ? prodS[63:32] : prodU[63:32];
      calcLo = isSigned ? prodS[31:0]  : prodU[31:0];
    end else if (opB == 32'd0) begin
      calcHi = opA;
      calcLo = 32'hFFFF_FFFF;
    end else if (isSigned) begin
      calcLo = (opA[31] ^ opB[31]) ? -quo : quo;
      calcHi = opA[31] ? -rem : rem;
    end else begin
      calcLo = quo;
      calcHi = rem;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      pendHi <= 32'd0;
      pendLo <= 32'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pendHi <= calcHi;
            pendLo <= calcLo;
            cnt    <= isMult ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
            busy   <= 1'b1;
            state  <= RUN;
          end else if (md_op == 3'd5) begin
            HI <= opA;
          end else if (md_op == 3'd6) begin
            LO <= opA;
          end
        end
        RUN: begin
          cnt <= cnt - CntW'(1);
          if (cnt == CntW'(1)) begin
            HI    <= pendHi;
            LO    <= pendLo;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - table-driven scoreboard bench for md_unit
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ForwardA, ForwardB;
  logic [31:0] RD1E, RD2E, FwdE, FwdM, FwdW;
  logic [2:0]  md_op;
  logic [31:0] opA, opB, HI, LO;
  logic        start, busy, md_stall;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .RD1E(RD1E), .RD2E(RD2E), .FwdE(FwdE), .FwdM(FwdM), .FwdW(FwdW),
    .md_op(md_op), .opA(opA), .opB(opB), .start(start), .busy(busy),
    .md_stall(md_stall), .HI(HI), .LO(LO)
  );

  typedef struct {
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, fe, fm, fw;
    logic [2:0]  op;
    logic [31:0] eOpA, eOpB;
    logic        eStart;
    logic [31:0] eHi, eLo;
    int          eCyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          cyc;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] fe, input logic [31:0] fm,
                       input logic [31:0] fw, input logic [2:0] op);
    ForwardA = fa; ForwardB = fb; RD1E = rd1; RD2E = rd2;
    FwdE = fe; FwdM = fm; FwdW = fw; md_op = op;
  endtask

  // Counts busy cycles seen at negedges, checking stall throughout; bounded.
  task automatic countBusy(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      check("stall_while_busy", 32'(md_stall), 32'd1);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic runVec(input int idx);
    vec_t v;
    exp_t e;
    int   cyc;
    v = vecs[idx];
    @(negedge clk);
    drive(v.fa, v.fb, v.rd1, v.rd2, v.fe, v.fm, v.fw, v.op);
    #1;
    check($sformatf("v%0d_opA", idx), opA, v.eOpA);
    check($sformatf("v%0d_opB", idx), opB, v.eOpB);
    check($sformatf("v%0d_start", idx), 32'(start), 32'(v.eStart));
    check($sformatf("v%0d_stall", idx), 32'(md_stall), 32'(v.eStart));
    sb.push_back('{v.eHi, v.eLo, v.eCyc});
    @(posedge clk);
    @(negedge clk);
    md_op = 3'd0;
    countBusy(cyc);
    e = sb.pop_front();
    check($sformatf("v%0d_cycles", idx), 32'(cyc), 32'(e.cyc));
    check($sformatf("v%0d_HI", idx), HI, e.hi);
    check($sformatf("v%0d_LO", idx), LO, e.lo);
  endtask

  initial begin
    int  cyc;
    logic seenBusy;

    vecs[0]  = '{2'd2, 2'd3, 32'd1, 32'd9, 32'd0, 32'd7, 32'hFFFF_FFFD, 3'd1,
                 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
    vecs[1]  = '{2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 3'd2,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2]  = '{2'd1, 2'd0, 32'd0, 32'd2, 32'hFFFF_FFF9, 32'd0, 32'd0, 3'd3,
                 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3]  = '{2'd0, 2'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 3'd4,
                 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF, 10};
    vecs[4]  = '{2'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 3'd3,
                 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 10};
    vecs[5]  = '{2'd0, 2'd0, 32'hFFFF_FFF8, 32'd0, 32'd0, 32'd0, 32'd0, 3'd3,
                 32'hFFFF_FFF8, 32'd0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 10};
    vecs[6]  = '{2'd0, 2'd2, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd0, 3'd3,
                 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 10};
    vecs[7]  = '{2'd0, 2'd1, 32'h0001_0000, 32'd0, 32'h0001_0000, 32'd0, 32'd0, 3'd2,
                 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd1, 32'd0, 5};
    vecs[8]  = '{2'd2, 2'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 3'd1,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd1, 5};
    vecs[9]  = '{2'd3, 2'd0, 32'd0, 32'd7, 32'd0, 32'd0, 32'd100, 3'd4,
                 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 10};
    vecs[10] = '{2'd3, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1234, 3'd5,
                 32'h1234, 32'd0, 1'b0, 32'h1234, 32'd14, 0};
    vecs[11] = '{2'd0, 2'd0, 32'h5678, 32'd3, 32'd0, 32'd0, 32'd0, 3'd6,
                 32'h5678, 32'd3, 1'b0, 32'h1234, 32'h5678, 0};
    vecs[12] = '{2'd0, 2'd0, 32'd99, 32'd3, 32'd0, 32'd0, 32'd0, 3'd7,
                 32'd99, 32'd3, 1'b0, 32'h1234, 32'h5678, 0};
    vecs[13] = '{2'd1, 2'd2, 32'd0, 32'd0, 32'd11, 32'd22, 32'd0, 3'd0,
                 32'd11, 32'd22, 1'b0, 32'h1234, 32'h5678, 0};

    reset = 1'b0;
    drive(2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(md_stall), 32'd0);
    check("rst_HI", HI, 32'd0);
    check("rst_LO", LO, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) runVec(i);

    // mthi then mtlo on consecutive cycles
    @(negedge clk);
    drive(2'd3, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hABCD, 3'd5);
    @(negedge clk);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_HI", HI, 32'hABCD);
    drive(2'd0, 2'd0, 32'hBEEF, 32'd0, 32'd0, 32'd0, 32'd0, 3'd6);
    @(negedge clk);
    md_op = 3'd0;
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_HI", HI, 32'hABCD);
    check("mtlo_LO", LO, 32'hBEEF);

    // op issued while busy is ignored
    @(negedge clk);
    drive(2'd0, 2'd0, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 3'd1);
    @(negedge clk);
    drive(2'd0, 2'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 3'd3);
    #1;
    check("busy_op_stall", 32'(md_stall), 32'd1);
    @(negedge clk);
    md_op = 3'd0;
    countBusy(cyc);
    check("busy_op_cycles", 32'(cyc + 1), 32'd5);
    check("busy_op_HI", HI, 32'd0);
    check("busy_op_LO", LO, 32'd6);
    repeat (3) @(negedge clk);
    check("busy_op_noretrigger", 32'(busy), 32'd0);
    check("busy_op_LO_hold", LO, 32'd6);

    // reset mid-divide aborts the operation
    @(negedge clk);
    drive(2'd0, 2'd0, 32'd100, 32'd7, 32'd0, 32'd0, 32'd0, 3'd3);
    @(negedge clk);
    md_op = 3'd0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_HI", HI, 32'd0);
    check("mid_rst_LO", LO, 32'd0);
    reset = 1'b1;
    seenBusy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy) seenBusy = 1'b1;
    end
    check("post_rst_nobusy", 32'(seenBusy), 32'd0);
    check("post_rst_HI", HI, 32'd0);
    check("post_rst_LO", LO, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
